// File: rtl/bus_load_bank.sv
// Register bank loaded from a shared bus. Destination code 15 starts a handshaked
// memory write that is aborted after MEM_TIMEOUT cycles without an acknowledge.
module bus_load_bank #(
    parameter int DATA_W      = 8,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic [3:0]        ld_sel,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    input  logic              inc_ar,
    input  logic              inc_rp,
    input  logic              clr_ac,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] AC,
    output logic [DATA_W-1:0] C3,
    output logic [DATA_W-1:0] C2,
    output logic [DATA_W-1:0] C1,
    output logic [DATA_W-1:0] RN2,
    output logic [DATA_W-1:0] RK2,
    output logic [DATA_W-1:0] RM2,
    output logic [DATA_W-1:0] RN1,
    output logic [DATA_W-1:0] RK1,
    output logic [DATA_W-1:0] RM1,
    output logic [DATA_W-1:0] RT,
    output logic [DATA_W-1:0] RP,
    output logic [DATA_W-1:0] DR,
    output logic [DATA_W-1:0] AR
);

    localparam int TMR_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int IDX_AC = 1;
    localparam int IDX_RP = 12;
    localparam int IDX_AR = 14;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] reg_q [1:14];
    logic [DATA_W-1:0] reg_d [1:14];
    logic              ld_accept;

    assign ld_accept = (state_q == IDLE) && ld_valid;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ld_ready = 1'b0;
        case (state_q)
            IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    if (ld_sel == 4'd0) begin
                        err_d = 1'b1;
                    end else if (ld_sel == 4'd15) begin
                        state_d = MEM_WAIT;
                        tmr_d   = TMR_W'(MEM_TIMEOUT - 1);
                        addr_d  = reg_q[IDX_AR];
                        wdata_d = bus_in;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                // An acknowledge arriving on the last allowed cycle still counts as success
                if (mem_ack) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tmr_q == '0) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 1; i <= 14; i++) reg_d[i] = reg_q[i];
        if (clr_ac) reg_d[IDX_AC] = '0;
        if (inc_rp) reg_d[IDX_RP] = reg_q[IDX_RP] + DATA_W'(1);
        if (inc_ar) reg_d[IDX_AR] = reg_q[IDX_AR] + DATA_W'(1);
        // Bus load applied last so it overrides any control on the same register
        if (ld_accept) begin
            for (int i = 1; i <= 14; i++) begin
                if (ld_sel == 4'(i)) reg_d[i] = bus_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            for (int i = 1; i <= 14; i++) reg_q[i] <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            for (int i = 1; i <= 14; i++) reg_q[i] <= reg_d[i];
        end
    end

    assign ld_done   = done_q;
    assign ld_err    = err_q;
    assign mem_we    = (state_q == MEM_WAIT);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign AC  = reg_q[1];
    assign C3  = reg_q[2];
    assign C2  = reg_q[3];
    assign C1  = reg_q[4];
    assign RN2 = reg_q[5];
    assign RK2 = reg_q[6];
    assign RM2 = reg_q[7];
    assign RN1 = reg_q[8];
    assign RK1 = reg_q[9];
    assign RM1 = reg_q[10];
    assign RT  = reg_q[11];
    assign RP  = reg_q[12];
    assign DR  = reg_q[13];
    assign AR  = reg_q[14];

endmodule

// File: doc/bus_load_bank.md
BUS_LOAD_BANK -- requirements
Module: bus_load_bank

Interface
- REQ-001 SHALL have parameter: DATA_W, default 8, width of the bus and of every register.
- REQ-002 SHALL have parameter: MEM_TIMEOUT, default 8, maximum cycles to wait for mem_ack before aborting.
- REQ-003 SHALL have port: clk, input, 1, the only clock; all state updates on its rising edge.
- REQ-004 SHALL have port: rst, input, 1, asynchronous active-high reset.
- REQ-005 SHALL have port: bus_in, input, DATA_W, the shared bus value to be loaded.
- REQ-006 SHALL have port: ld_sel, input, 4, destination code: 1 AC, 2 C3, 3 C2, 4 C1, 5 RN2, 6 RK2, 7 RM2, 8 RN1, 9 RK1, 10 RM1, 11 RT, 12 RP, 13 DR, 14 AR, 15 MEM, 0 none.
- REQ-007 SHALL have port: ld_valid, input, 1, load request qualifier.
- REQ-008 SHALL have port: ld_ready, output, 1, high when a request is accepted this cycle.
- REQ-009 SHALL have port: ld_done, output, 1, one-cycle pulse when a load completes.
- REQ-010 SHALL have port: ld_err, output, 1, one-cycle pulse on an illegal code (0) or a memory timeout.
- REQ-011 SHALL have ports: inc_ar, inc_rp, clr_ac, input, 1 each, AR increment, RP increment and AC clear controls.
- REQ-012 SHALL have ports: mem_we, output, 1; mem_addr, output, DATA_W; mem_wdata, output, DATA_W; mem_ack, input, 1.
- REQ-013 SHALL have ports: AC, C3, C2, C1, RN2, RK2, RM2, RN1, RK1, RM1, RT, RP, DR, AR, output, DATA_W each, the register contents.

Function
- REQ-014 SHALL implement FSM states IDLE and MEM_WAIT.
- REQ-015 In IDLE, ld_ready SHALL be 1; in MEM_WAIT, ld_ready SHALL be 0 and ld_valid SHALL be ignored.
- REQ-016 In IDLE with ld_valid=1 and ld_sel in 1..14, the selected register SHALL take bus_in at the next edge, and ld_done SHALL pulse in that same cycle (registered, 1-cycle latency).
- REQ-017 In IDLE with ld_valid=1 and ld_sel=15, the block SHALL enter MEM_WAIT, latch mem_wdata=bus_in and mem_addr=AR, and assert mem_we from the next cycle.
- REQ-018 In MEM_WAIT, mem_we SHALL stay 1 and mem_addr/mem_wdata SHALL stay stable until mem_ack=1.
- REQ-019 On mem_ack=1, the block SHALL deassert mem_we, pulse ld_done and return to IDLE at the next edge.
- REQ-020 The timeout counter SHALL reset on entry to MEM_WAIT; if MEM_TIMEOUT cycles pass without mem_ack, the block SHALL drop mem_we, pulse ld_err (not ld_done) and return to IDLE.
- REQ-021 ld_valid=1 with ld_sel=0 in IDLE SHALL pulse ld_err and change no register.
- REQ-022 inc_ar SHALL add 1 to AR modulo 2^DATA_W (0xFF wraps to 0x00); inc_rp SHALL do the same for RP; clr_ac SHALL load AC with 0.
- REQ-023 A bus load to the same register in the same cycle SHALL take priority over inc_ar, inc_rp or clr_ac; the losing control SHALL be dropped.
- REQ-024 inc_ar, inc_rp and clr_ac SHALL operate in both states; during MEM_WAIT, AR changes SHALL NOT affect the latched mem_addr.
- REQ-025 Registers not addressed by a load or control SHALL hold their value.

Reset
- REQ-026 rst=1 SHALL immediately, without waiting for clk, set all 14 registers, mem_addr and mem_wdata to 0, mem_we, ld_done and ld_err to 0, and the FSM to IDLE.
- REQ-027 rst asserted during MEM_WAIT SHALL abort the write with no ld_done or ld_err pulse.

Verification
- REQ-028 Load bus_in=0x5A, ld_sel=1 -> AC=0x5A next cycle, ld_done pulses once, other registers unchanged.
- REQ-029 AR=0x20, load bus_in=0x77 with ld_sel=15, mem_ack after 3 cycles -> mem_we high for 3 cycles with addr 0x20 and data 0x77, then ld_done, then ld_ready=1.
- REQ-030 ld_sel=15 with mem_ack never asserted -> mem_we drops after 8 cycles, ld_err pulses, FSM returns to IDLE.
- REQ-031 AR=0xFF with inc_ar -> AR=0x00; in the same cycle, loading RP=0x10 together with inc_rp -> RP=0x10.
- REQ-032 ld_sel=0 with ld_valid -> ld_err pulses and all registers unchanged.
- REQ-033 rst asserted mid-MEM_WAIT between clock edges -> mem_we=0 and all registers 0 at once, no ld_done.
